tpu_host_loader: RTL
====================

// Module: tpu_host_loader
// PURPOSE
//  Upstream/downstream host adapter for the TPU. Packs a host byte stream into 32-bit words,
//  writes matrix A then matrix B into the global buffers, pulses TPU start, waits for done,
//  then streams the result words back out of the output global buffer to the host.
//  Sits between the host interface and the gbuff_a/gbuff_b/gbuff_o buffers feeding the TPU.
// PARAMETERS
//  DATA_SIZE  8   element width; bytes per word = WORD_SIZE/DATA_SIZE = 4
//  WORD_SIZE  32  global-buffer word width
//  ADDR_SIZE  8   global-buffer index width
// PORTS
//  clk          in   1          clock, all logic on rising edge
//  rst          in   1          synchronous active-high reset
//  cfg_valid    in   1          job config strobe; sampled only in IDLE
//  cfg_a_words  in   ADDR_SIZE  number of A words to load (0..255)
//  cfg_b_words  in   ADDR_SIZE  number of B words to load (0..255)
//  cfg_o_words  in   ADDR_SIZE  number of O words to drain (0..255)
//  cfg_m/n/k    in   4 each     matrix dims, latched and driven to TPU as m/n/k
//  in_valid     in   1          host byte valid
//  in_ready     out  1          loader accepts byte (transfer = in_valid & in_ready)
//  in_data      in   DATA_SIZE  host byte
//  wr_en_a      out  1          gbuff_a write strobe; wr_en_b same for gbuff_b
//  index_a/b    out  ADDR_SIZE  write index; data_a/b out WORD_SIZE write data
//  tpu_m/n/k    out  4 each     latched dims to TPU
//  tpu_start    out  1          one-cycle start pulse to TPU
//  tpu_done     in   1          TPU done level
//  index_o      out  ADDR_SIZE  gbuff_o read index; data_o in WORD_SIZE (1-cycle read latency)
//  out_valid    out  1          result word valid; out_ready in 1 host accept
//  out_data     out  WORD_SIZE  result word
//  busy         out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (in_ready, wr_en_*, index_*, data_*, tpu_*, out_*, busy);
//   packer byte count 0; holding register invalid. Reset mid-job aborts immediately, no flush.
//  States: IDLE -> LOAD_A -> LOAD_B -> START -> WAIT -> DRAIN -> IDLE.
//  IDLE: cfg_valid=1 latches cfg_*; next LOAD_A (or LOAD_B if a_words=0, START if both 0).
//  LOAD_A/LOAD_B: in_ready=1. Bytes packed big-endian: 1st byte -> [31:24], 4th -> [7:0].
//   On 4th accepted byte, next cycle wr_en=1 for exactly one cycle with full word, index = word
//   count (starts 0, +1 per write). in_ready stays 1 during the write cycle (no bubble).
//   After word a_words-1 is written -> LOAD_B (b_words=0 -> START). Same for B -> START.
//   Gaps in in_valid stall packing; partial word is never written.
//  START: tpu_start=1 one cycle; -> WAIT. WAIT: in_ready=0; on tpu_done=1 -> DRAIN
//   (o_words=0 -> IDLE). tpu_done already high in START cycle is ignored (sampled from WAIT).
//  DRAIN: index_o issues 0..o_words-1; data_o valid one cycle after issue. Two-entry skid buffer:
//   index advances only if a slot will be free, so no word is lost/duplicated under out_ready=0.
//   out_data holds stable while out_valid & !out_ready. Full rate (1 word/cycle) when out_ready=1.
//   After last word accepted -> IDLE next cycle; busy falls same edge.
//  Index arithmetic is ADDR_SIZE modulo; word counts <=255 so no wrap in a legal job.
//  cfg_valid outside IDLE ignored; in_valid outside LOAD_* ignored (in_ready=0).
// TESTING
//  1) a=1,b=1,o=1: bytes 11 22 33 44 | 55 66 77 88 -> wr_en_a idx0 data 0x11223344,
//     wr_en_b idx0 0x55667788, one tpu_start pulse, o word 0 on out_data after done.
//  2) a=4,b=4 at full in_valid -> writes every 4 cycles, indexes 0..3, no lost byte.
//  3) a=0,b=2 -> no wr_en_a, LOAD_B directly; b=0,a=0,o=0 -> start pulse then IDLE on done.
//  4) o=8, out_ready toggled 1,0,0,1 pattern -> out_data sequence equals gbuff_o[0..7] exactly.
//  5) tpu_done held high before start -> start still pulses once; WAIT exits next cycle.
//  6) rst asserted mid-LOAD_B and mid-DRAIN -> next cycle IDLE, all outputs 0; new job runs clean.

Source files
------------

// File: rtl/tpu_host_loader.sv
// Host adapter for the TPU: packs host bytes into words for gbuff_a/gbuff_b, runs the
// start/done handshake, then streams gbuff_o results back through a two-entry skid buffer.
`timescale 1ns/1ps
module tpu_host_loader #(
  parameter int DATA_SIZE = 8,
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  input  logic [ADDR_SIZE-1:0] cfg_a_words,
  input  logic [ADDR_SIZE-1:0] cfg_b_words,
  input  logic [ADDR_SIZE-1:0] cfg_o_words,
  input  logic [3:0]           cfg_m,
  input  logic [3:0]           cfg_n,
  input  logic [3:0]           cfg_k,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 wr_en_a,
  output logic [ADDR_SIZE-1:0] index_a,
  output logic [WORD_SIZE-1:0] data_a,
  output logic                 wr_en_b,
  output logic [ADDR_SIZE-1:0] index_b,
  output logic [WORD_SIZE-1:0] data_b,
  output logic [3:0]           tpu_m,
  output logic [3:0]           tpu_n,
  output logic [3:0]           tpu_k,
  output logic                 tpu_start,
  input  logic                 tpu_done,
  output logic [ADDR_SIZE-1:0] index_o,
  input  logic [WORD_SIZE-1:0] data_o,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 busy
);

  localparam int BYTES = WORD_SIZE / DATA_SIZE;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  state_t                 state_r, state_s;
  logic [ADDR_SIZE-1:0]   a_words_r, b_words_r, o_words_r;
  logic [BCW-1:0]         byte_cnt_r;
  logic [ADDR_SIZE-1:0]   word_cnt_r;
  logic [WORD_SIZE-1:0]   shift_r;
  logic                   in_ready_r, busy_r, tpu_start_r;
  logic                   wr_en_a_r, wr_en_b_r;
  logic [ADDR_SIZE-1:0]   index_a_r, index_b_r, index_o_r;
  logic [WORD_SIZE-1:0]   data_a_r, data_b_r;
  logic [3:0]             tpu_m_r, tpu_n_r, tpu_k_r;
  logic                   pending_r;
  logic                   out_valid_r, skid_valid_r;
  logic [WORD_SIZE-1:0]   out_data_r, skid_data_r;

  logic                   accept_s, byte_last_s, word_last_s, pop_s, issue_s, last_pop_s;
  logic [1:0]             occ_s;
  logic [WORD_SIZE-1:0]   word_s;
  logic                   head_v_s, skid_v_s;
  logic [WORD_SIZE-1:0]   head_d_s, skid_d_s;

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign tpu_start = tpu_start_r;
  assign wr_en_a   = wr_en_a_r;
  assign wr_en_b   = wr_en_b_r;
  assign index_a   = index_a_r;
  assign index_b   = index_b_r;
  assign data_a    = data_a_r;
  assign data_b    = data_b_r;
  assign tpu_m     = tpu_m_r;
  assign tpu_n     = tpu_n_r;
  assign tpu_k     = tpu_k_r;
  assign index_o   = index_o_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Packer and drain-side control flags
  always_comb begin
    accept_s    = in_valid & in_ready_r;
    byte_last_s = (byte_cnt_r == BCW'(BYTES - 1));
    word_s      = {shift_r[WORD_SIZE-DATA_SIZE-1:0], in_data};
    if (state_r == LOAD_A) begin
      word_last_s = (word_cnt_r == a_words_r - ADDR_SIZE'(1));
    end else begin
      word_last_s = (word_cnt_r == b_words_r - ADDR_SIZE'(1));
    end
    pop_s = out_valid_r & out_ready;
    // Slots still committed after this edge; an issue now lands two edges later.
    occ_s = 2'(out_valid_r) + 2'(skid_valid_r) + 2'(pending_r) - 2'(pop_s);
    issue_s = (state_r == DRAIN) && (index_o_r != o_words_r) && (occ_s <= 2'd1);
    last_pop_s = (state_r == DRAIN) && pop_s && (index_o_r == o_words_r) &&
                 !skid_valid_r && !pending_r;
  end

  // Skid buffer next values: head feeds out_data, second slot absorbs a stalled read
  always_comb begin
    head_v_s = out_valid_r;
    head_d_s = out_data_r;
    skid_v_s = skid_valid_r;
    skid_d_s = skid_data_r;
    if (pop_s) begin
      if (skid_valid_r) begin
        head_v_s = 1'b1;
        head_d_s = skid_data_r;
        skid_v_s = pending_r;
        if (pending_r) begin
          skid_d_s = data_o;
        end else begin
          skid_d_s = skid_data_r;
        end
      end else if (pending_r) begin
        head_v_s = 1'b1;
        head_d_s = data_o;
      end else begin
        head_v_s = 1'b0;
      end
    end else if (pending_r) begin
      if (!out_valid_r) begin
        head_v_s = 1'b1;
        head_d_s = data_o;
      end else begin
        skid_v_s = 1'b1;
        skid_d_s = data_o;
      end
    end else begin
      head_v_s = out_valid_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!cfg_valid) begin
          state_s = IDLE;
        end else if (cfg_a_words != ADDR_SIZE'(0)) begin
          state_s = LOAD_A;
        end else if (cfg_b_words != ADDR_SIZE'(0)) begin
          state_s = LOAD_B;
        end else begin
          state_s = START;
        end
      end
      LOAD_A: begin
        if (accept_s && byte_last_s && word_last_s) begin
          state_s = (b_words_r != ADDR_SIZE'(0)) ? LOAD_B : START;
        end else begin
          state_s = LOAD_A;
        end
      end
      LOAD_B: begin
        if (accept_s && byte_last_s && word_last_s) begin
          state_s = START;
        end else begin
          state_s = LOAD_B;
        end
      end
      START: state_s = WAIT;
      WAIT: begin
        if (tpu_done) begin
          state_s = (o_words_r != ADDR_SIZE'(0)) ? DRAIN : IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      DRAIN: begin
        if (last_pop_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_words_r    <= ADDR_SIZE'(0);
      b_words_r    <= ADDR_SIZE'(0);
      o_words_r    <= ADDR_SIZE'(0);
      byte_cnt_r   <= BCW'(0);
      word_cnt_r   <= ADDR_SIZE'(0);
      shift_r      <= WORD_SIZE'(0);
      in_ready_r   <= 1'b0;
      busy_r       <= 1'b0;
      tpu_start_r  <= 1'b0;
      wr_en_a_r    <= 1'b0;
      wr_en_b_r    <= 1'b0;
      index_a_r    <= ADDR_SIZE'(0);
      index_b_r    <= ADDR_SIZE'(0);
      data_a_r     <= WORD_SIZE'(0);
      data_b_r     <= WORD_SIZE'(0);
      tpu_m_r      <= 4'd0;
      tpu_n_r      <= 4'd0;
      tpu_k_r      <= 4'd0;
      index_o_r    <= ADDR_SIZE'(0);
      pending_r    <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= WORD_SIZE'(0);
      skid_valid_r <= 1'b0;
      skid_data_r  <= WORD_SIZE'(0);
    end else begin
      in_ready_r  <= (state_s == LOAD_A) || (state_s == LOAD_B);
      busy_r      <= (state_s != IDLE);
      tpu_start_r <= (state_s == START);
      wr_en_a_r   <= 1'b0;
      wr_en_b_r   <= 1'b0;
      if (state_r == IDLE && cfg_valid) begin
        a_words_r <= cfg_a_words;
        b_words_r <= cfg_b_words;
        o_words_r <= cfg_o_words;
        tpu_m_r   <= cfg_m;
        tpu_n_r   <= cfg_n;
        tpu_k_r   <= cfg_k;
      end
      if (accept_s) begin
        shift_r <= word_s;
        if (byte_last_s) begin
          byte_cnt_r <= BCW'(0);
          word_cnt_r <= word_last_s ? ADDR_SIZE'(0) : word_cnt_r + ADDR_SIZE'(1);
          if (state_r == LOAD_A) begin
            wr_en_a_r <= 1'b1;
            index_a_r <= word_cnt_r;
            data_a_r  <= word_s;
          end else begin
            wr_en_b_r <= 1'b1;
            index_b_r <= word_cnt_r;
            data_b_r  <= word_s;
          end
        end else begin
          byte_cnt_r <= byte_cnt_r + BCW'(1);
        end
      end
      pending_r    <= issue_s;
      out_valid_r  <= head_v_s;
      out_data_r   <= head_d_s;
      skid_valid_r <= skid_v_s;
      skid_data_r  <= skid_d_s;
      if (last_pop_s) begin
        index_o_r <= ADDR_SIZE'(0);
      end else if (issue_s) begin
        index_o_r <= index_o_r + ADDR_SIZE'(1);
      end
    end
  end

endmodule
